// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared constants for the 1x3 router ingress controller: port count, the
// reserved destination address and the 3-bit FSM state encoding.
// ---------------------------------------------------------------------------
package router_pkg;

  localparam int NUM_PORTS = 3;

  // Destination address 3 has no output FIFO; such headers are dropped.
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
  localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd1;
  localparam logic [2:0] LOAD_FIRST_DATA    = 3'd2;
  localparam logic [2:0] LOAD_DATA          = 3'd3;
  localparam logic [2:0] FIFO_FULL_STATE    = 3'd4;
  localparam logic [2:0] LOAD_AFTER_FULL    = 3'd5;
  localparam logic [2:0] LOAD_PARITY        = 3'd6;
  localparam logic [2:0] CHECK_PARITY_ERROR = 3'd7;

endpackage

// File: rtl/router_if.sv
// ---------------------------------------------------------------------------
// router_if
// Bundle of the ingress controller's handshake and FIFO status signals.
// Names are given from the controller's point of view: i_* flow into the
// controller, o_* flow out of it.
//   slave  : the controller (router_fsm)
//   master : the surrounding logic (register block, FIFOs, downstream readers)
// ---------------------------------------------------------------------------
interface router_if;
  import router_pkg::*;

  logic                 i_pkt_valid;
  logic [1:0]           i_data_in;
  logic                 i_parity_done;
  logic                 i_low_pkt_valid;
  logic [NUM_PORTS-1:0] i_fifo_full;
  logic [NUM_PORTS-1:0] i_fifo_empty;
  logic [NUM_PORTS-1:0] i_read_enb;

  logic [NUM_PORTS-1:0] o_write_enb;
  logic [NUM_PORTS-1:0] o_soft_reset;
  logic [NUM_PORTS-1:0] o_vld_out;
  logic                 o_detect_add;
  logic                 o_lfd_state;
  logic                 o_ld_state;
  logic                 o_laf_state;
  logic                 o_rst_int_reg;
  logic                 o_busy;

  modport slave (
    input  i_pkt_valid, i_data_in, i_parity_done, i_low_pkt_valid,
           i_fifo_full, i_fifo_empty, i_read_enb,
    output o_write_enb, o_soft_reset, o_vld_out, o_detect_add,
           o_lfd_state, o_ld_state, o_laf_state, o_rst_int_reg, o_busy
  );

  modport master (
    output i_pkt_valid, i_data_in, i_parity_done, i_low_pkt_valid,
           i_fifo_full, i_fifo_empty, i_read_enb,
    input  o_write_enb, o_soft_reset, o_vld_out, o_detect_add,
           o_lfd_state, o_ld_state, o_laf_state, o_rst_int_reg, o_busy
  );

endinterface

// File: rtl/router_timeout.sv
// ---------------------------------------------------------------------------
// router_timeout
// Idle-read watchdog for one output port. Counts cycles in which the port
// holds data but is not being read; after TIMEOUT such cycles it emits a
// one-cycle o_soft_reset pulse so the stale FIFO gets flushed.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   i_vld        port has data pending (~fifo_empty)
//   i_read_enb   downstream read enable for this port
//   o_soft_reset registered one-cycle flush pulse
// ---------------------------------------------------------------------------
module router_timeout #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_vld,
  input  logic i_read_enb,
  output logic o_soft_reset
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_soft_reset;
  logic             w_clear;
  logic             w_expire;

  // Any read, or an empty FIFO, means the port is not stale.
  assign w_clear  = i_read_enb || !i_vld;
  assign w_expire = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Counter wraps to zero on expiry so the flush pulse lasts one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else begin
      r_soft_reset <= !w_clear && w_expire;
      if (w_clear || w_expire)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_soft_reset = r_soft_reset;

endmodule

// File: rtl/router_fsm.sv
// ---------------------------------------------------------------------------
// router_fsm
// Ingress controller for the 1x3 router. Decodes the header address, picks
// the output FIFO, sequences header/payload/parity writes, stalls on a full
// FIFO and flushes ports whose data sits unread for TIMEOUT cycles.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   bus         router_if.slave: pkt_valid, data_in, parity_done,
//               low_pkt_valid, fifo_full/empty, read_enb in; write_enb,
//               soft_reset, vld_out, state decodes and busy out
// ---------------------------------------------------------------------------
module router_fsm
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic     clk,
  input  logic     reset,
  router_if.slave  bus
);

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic [1:0]           r_sel;
  logic [1:0]           w_addr;
  logic                 w_addr_ok;
  logic                 w_write_phase;
  logic [NUM_PORTS-1:0] w_soft_reset;
  // Padded to 4 bits so a 2-bit index never falls outside the vector.
  logic [3:0]           w_full_pad;
  logic [3:0]           w_empty_pad;
  logic [3:0]           w_soft_pad;

  assign w_addr      = bus.i_data_in;
  assign w_addr_ok   = bus.i_pkt_valid && (w_addr != ADDR_INVALID);
  assign w_full_pad  = {1'b0, bus.i_fifo_full};
  assign w_empty_pad = {1'b0, bus.i_fifo_empty};
  assign w_soft_pad  = {1'b0, w_soft_reset};

  genvar k;
  generate
    for (k = 0; k < NUM_PORTS; k++) begin : g_port
      router_timeout #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
      ) u_timeout (
        .clk          (clk),
        .reset        (reset),
        .i_vld        (!bus.i_fifo_empty[k]),
        .i_read_enb   (bus.i_read_enb[k]),
        .o_soft_reset (w_soft_reset[k])
      );

      // A full FIFO masks its write so no byte is ever pushed into it.
      assign bus.o_write_enb[k] = w_write_phase && (r_sel == 2'(k)) && !bus.i_fifo_full[k];
    end
  endgenerate

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= DECODE_ADDRESS;
    else
      r_state <= w_next;
  end

  // Destination is latched only for a valid, routable header.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_sel <= 2'd0;
    else if (r_state == DECODE_ADDRESS && w_addr_ok)
      r_sel <= w_addr;
  end

  // Next-state logic; a flush of the selected port overrides everything.
  always_comb begin
    w_next = r_state;
    case (r_state)
      DECODE_ADDRESS:
        if (w_addr_ok)
          w_next = w_empty_pad[w_addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:
        if (w_empty_pad[r_sel]) w_next = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:
        w_next = LOAD_DATA;
      LOAD_DATA:
        if (w_full_pad[r_sel])     w_next = FIFO_FULL_STATE;
        else if (!bus.i_pkt_valid) w_next = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!w_full_pad[r_sel]) w_next = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (bus.i_parity_done)        w_next = DECODE_ADDRESS;
        else if (bus.i_low_pkt_valid) w_next = LOAD_PARITY;
        else                          w_next = LOAD_DATA;
      LOAD_PARITY:
        w_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        w_next = w_full_pad[r_sel] ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:
        w_next = DECODE_ADDRESS;
    endcase
    if (r_state != DECODE_ADDRESS && w_soft_pad[r_sel])
      w_next = DECODE_ADDRESS;
  end

  assign w_write_phase = (r_state == LOAD_FIRST_DATA) || (r_state == LOAD_DATA) ||
                         (r_state == LOAD_AFTER_FULL) || (r_state == LOAD_PARITY);

  assign bus.o_detect_add  = (r_state == DECODE_ADDRESS);
  assign bus.o_lfd_state   = (r_state == LOAD_FIRST_DATA);
  assign bus.o_ld_state    = (r_state == LOAD_DATA);
  assign bus.o_laf_state   = (r_state == LOAD_AFTER_FULL);
  assign bus.o_rst_int_reg = (r_state == CHECK_PARITY_ERROR);
  assign bus.o_busy        = (r_state != DECODE_ADDRESS) && (r_state != LOAD_DATA);
  assign bus.o_soft_reset  = w_soft_reset;
  assign bus.o_vld_out     = ~bus.i_fifo_empty;

endmodule
